// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RV32 core.
//
// Holds the program counter and issues one word fetch at a time to
// instruction memory. Each fetched instruction is delivered to decode as
// {pc, instruction} through the IF/ID register. A one-entry skid buffer
// catches a response that arrives while decode is stalling. A redirect from
// execute flushes everything fetched but not yet consumed.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req / imem_addr        fetch request and word address (held until rvalid)
//   imem_rvalid / imem_rdata    fetch response
//   redirect_valid/redirect_pc  taken branch/jump from execute (1-cycle pulse)
//   id_ready                    decode accepts the IF/ID contents this cycle
//   if_id_valid/_pc/_instr      IF/ID pipeline register outputs
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Address of the request being discarded; pc_q already holds the target.
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic consume;

  assign consume     = id_ready & ifid_valid_q;
  assign imem_req    = (state_q == S_WAIT) || (state_q == S_DROP);
  assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign if_id_valid = ifid_valid_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_instr = ifid_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (redirect_valid) begin
      // Redirect beats stall, accept and drain: flush and retarget.
      ifid_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = {redirect_pc[31:2], 2'b00};
      case (state_q)
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_WAIT;  // response completes now and is simply ignored
          end else begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end
        S_DROP:  state_d = imem_rvalid ? S_WAIT : S_DROP;
        default: state_d = S_WAIT;
      endcase
    end else begin
      // Default: a consumed IF/ID entry empties unless refilled below.
      if (consume) begin
        ifid_valid_d = 1'b0;
      end
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_WAIT;
          end
        end
        S_FULL: begin
          if (consume) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
            state_d      = S_WAIT;
          end
        end
        default: begin  // S_WAIT
          if (imem_rvalid) begin
            pc_d = pc_q + 32'd4;
            if (!ifid_valid_q || id_ready) begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = pc_q;
              ifid_instr_d = imem_rdata;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = pc_q;
              skid_instr_d = imem_rdata;
              state_d      = S_FULL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a latency-programmable
// instruction memory model (data = addr ^ 0xA5A5_0000) and a scoreboard of
// expected delivered PCs, compared whenever decode consumes IF/ID.
module tb_fetch_stage;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] IMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b1;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int checks = 0;
  int errors = 0;
  int unsigned lat = 0;
  int unsigned cnt;
  logic [31:0] sb_q[$];

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
  );

  always #5 clk = ~clk;

  // Memory model: responds after lat cycles of a held request (lat=0: same cycle).
  assign imem_rvalid = imem_req && (cnt >= lat);
  assign imem_rdata  = imem_addr ^ IMASK;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (!imem_req || imem_rvalid) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start);
    logic [31:0] p;
    sb_q.delete();
    p = start;
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // One step: land 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
    chk({tag, "_pc"}, if_id_pc, pc);
    chk({tag, "_instr"}, if_id_instr, pc ^ IMASK);
  endtask

  // Asserts reset, checks reset values, releases; the next edge is the first
  // post-reset edge.
  task automatic do_reset(input int unsigned l);
    step();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    lat = l;
    sb_load(RPC);
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  // Scoreboard: every consumption (not cancelled by a redirect) must match the
  // next expected PC in order.
  always @(negedge clk) begin
    if (rst_n && if_id_valid && id_ready && !redirect_valid) begin
      chk("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
      if (sb_q.size() != 0) begin
        logic [31:0] e;
        e = sb_q.pop_front();
        $display("deliver pc=%h instr=%h exp_pc=%h", if_id_pc, if_id_instr, e);
        chk("sb_pc", if_id_pc, e);
        chk("sb_instr", if_id_instr, e ^ IMASK);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset / sequential fetch, zero latency.
    do_reset(0);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    step(); chk_ifid("seq0", 32'h100);
    step(); chk_ifid("seq1", 32'h104);
    step(); chk_ifid("seq2", 32'h108);

    // Back-pressure: stall 5 cycles with 0x104 in IF/ID.
    do_reset(0);
    step();
    step(); chk_ifid("bp0", 32'h100);
    step(); chk_ifid("bp1", 32'h104);
    id_ready = 1'b0;
    step(); chk("bp_req_drop", {31'd0, imem_req}, 32'd0); chk_ifid("bp_hold0", 32'h104);
    step(); chk_ifid("bp_hold1", 32'h104);
    step(); chk_ifid("bp_hold2", 32'h104);
    step(); chk("bp_req_drop2", {31'd0, imem_req}, 32'd0);
    step(); id_ready = 1'b1;
    step(); chk_ifid("bp_drain", 32'h108);
    chk("bp_req_back", {31'd0, imem_req}, 32'd1);
    chk("bp_addr_back", imem_addr, 32'h10C);
    step(); chk_ifid("bp_next", 32'h10C);

    // Redirect with an outstanding fetch, 3-cycle memory.
    do_reset(2);
    step(); step(); step();
    step(); chk_ifid("rd_first", 32'h100);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    sb_load(32'h200);
    step();
    redirect_valid = 1'b0;
    chk("rd_flush", {31'd0, if_id_valid}, 32'd0);
    chk("rd_drop_req", {31'd0, imem_req}, 32'd1);
    chk("rd_drop_addr", imem_addr, 32'h104);
    step();
    chk("rd_new_addr", imem_addr, 32'h200);
    chk("rd_new_req", {31'd0, imem_req}, 32'd1);
    chk("rd_still_empty", {31'd0, if_id_valid}, 32'd0);
    step(); step();
    chk("rd_wait_empty", {31'd0, if_id_valid}, 32'd0);
    step(); chk_ifid("rd_target", 32'h200);

    // Redirect coincident with rvalid while decode stalls.
    do_reset(0);
    step();
    step(); chk_ifid("cr0", 32'h100);
    step(); chk_ifid("cr1", 32'h104);
    id_ready = 1'b0;
    step(); chk("cr_full_req", {31'd0, imem_req}, 32'd0);
    id_ready = 1'b1;
    step(); chk_ifid("cr_drain", 32'h108);
    chk("cr_addr10c", imem_addr, 32'h10C);
    id_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h303;
    sb_load(32'h300);
    step();
    redirect_valid = 1'b0; id_ready = 1'b1;
    chk("cr_flush", {31'd0, if_id_valid}, 32'd0);
    chk("cr_addr", imem_addr, 32'h300);
    chk("cr_req", {31'd0, imem_req}, 32'd1);
    step(); chk_ifid("cr_target", 32'h300);
    step(); chk_ifid("cr_target1", 32'h304);

    // Redirect out of FULL into the top of memory, then PC wrap.
    do_reset(0);
    step();
    step(); chk_ifid("wr0", 32'h100);
    id_ready = 1'b0;
    step(); chk("wr_full_req", {31'd0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFA; id_ready = 1'b1;
    sb_load(32'hFFFF_FFF8);
    step();
    redirect_valid = 1'b0;
    chk("wr_flush", {31'd0, if_id_valid}, 32'd0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFF8);
    step(); chk_ifid("wr_a", 32'hFFFF_FFF8);
    step(); chk_ifid("wr_b", 32'hFFFF_FFFC);
    step(); chk_ifid("wr_c", 32'h0000_0000);

    // Asynchronous reset while FULL, then restart.
    do_reset(0);
    step();
    step(); id_ready = 1'b0;
    step(); chk("mr_full_req", {31'd0, imem_req}, 32'd0);
    #1;
    rst_n = 1'b0;
    id_ready = 1'b1;
    sb_load(RPC);
    #1;
    chk("mr_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mr_pc", if_id_pc, 32'd0);
    chk("mr_instr", if_id_instr, 32'd0);
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_addr", imem_addr, RPC);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_restart_req", {31'd0, imem_req}, 32'd1);
    chk("mr_restart_addr", imem_addr, RPC);
    step(); chk_ifid("mr0", 32'h100);
    step(); chk_ifid("mr1", 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
